sysid_info_regs: RTL and testbench

Parametrised system-identification and uptime register block on the Nios II Avalon-MM fabric, the successor to the fixed two-word system ID slave. It exposes the system ID, build timestamp, a capability word, a scratch register, a configurable bank of constant user words, and a prescaled 64-bit uptime counter with atomic high-word snapshot. Reads are registered, with fixed latency 1 and `readdatavalid`, so the block can sit behind pipelined bridges.

---
 rtl/sysid_info_regs_if.sv | 33 +++
 rtl/sysid_info_regs.sv | 128 ++++++++++++
 tb/tb_sysid_info_regs.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/sysid_info_regs_if.sv
// ---------------------------------------------------------------------------
// sysid_info_regs_if
// Avalon-MM slave bundle for the system-identification register block.
//   address       word address (ADDR_W bits)
//   read / write  single-cycle transfer strobes
//   writedata     32-bit write data
//   byteenable    per-byte write lanes
//   readdata      registered read data, driven by the slave
//   readdatavalid one-cycle pulse marking readdata, driven by the slave
// ---------------------------------------------------------------------------
interface sysid_info_regs_if #(
  parameter int ADDR_W = 4
) ();

  logic [ADDR_W-1:0] address;
  logic              read;
  logic              write;
  logic [31:0]       writedata;
  logic [3:0]        byteenable;
  logic [31:0]       readdata;
  logic              readdatavalid;

  modport master (
    output address, read, write, writedata, byteenable,
    input  readdata, readdatavalid
  );

  modport slave (
    input  address, read, write, writedata, byteenable,
    output readdata, readdatavalid
  );

endinterface

// File: rtl/sysid_info_regs.sv
// ---------------------------------------------------------------------------
// sysid_info_regs
// System ID / build timestamp / capability / scratch / user constant words
// plus a prescaled 64-bit uptime counter with a coherent high-word snapshot.
// Reads are registered with a fixed latency of one cycle.
//   clock    sole clock, rising edge
//   reset_n  asynchronous active-low reset
//   bus      Avalon-MM slave (see sysid_info_regs_if)
// ---------------------------------------------------------------------------
module sysid_info_regs #(
  parameter logic [31:0] SYSTEM_ID = 32'h511E_D0FA,
  parameter logic [31:0] TIMESTAMP = 32'd0,
  parameter logic [7:0]  VERSION   = 8'd2,
  parameter int          ADDR_W    = 4,
  parameter int          NUM_USER  = 2,
  parameter logic [((NUM_USER > 0) ? NUM_USER : 1)*32-1:0] USER_WORDS = '0,
  parameter int          PRESCALE  = 1
) (
  input logic               clock,
  input logic               reset_n,
  sysid_info_regs_if.slave  bus
);

  localparam logic [ADDR_W-1:0] ADDR_SYSID     = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] ADDR_TIMESTAMP = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_UPTIME_LO = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] ADDR_UPTIME_HI = ADDR_W'(3);
  localparam logic [ADDR_W-1:0] ADDR_SCRATCH   = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] ADDR_CAPS      = ADDR_W'(5);

  localparam logic [31:0] CAPS_WORD   = {16'(NUM_USER), 8'(ADDR_W), VERSION};
  localparam logic [15:0] PRE_LAST    = 16'(PRESCALE - 1);

  logic [63:0] r_counter;
  logic [15:0] r_preCnt;
  logic [31:0] r_hiShadow;
  logic [31:0] r_scratch;
  logic [31:0] r_readdata;
  logic        r_readdatavalid;

  logic [31:0] w_readMux;
  logic [31:0] w_scratchNext;
  logic        w_wrEn;
  logic        w_clear;
  logic        w_tick;

  // A simultaneous read takes priority, so the write is simply dropped.
  assign w_wrEn  = bus.write & ~bus.read;
  assign w_clear = w_wrEn & (bus.address == ADDR_UPTIME_LO);
  assign w_tick  = (r_preCnt == PRE_LAST);

  assign bus.readdata      = r_readdata;
  assign bus.readdatavalid = r_readdatavalid;

  // Read multiplexer; the uptime value is the pre-increment counter so the
  // LO word and the shadowed HI word always come from the same sample.
  always_comb begin
    w_readMux = 32'd0;
    case (bus.address)
      ADDR_SYSID:     w_readMux = SYSTEM_ID;
      ADDR_TIMESTAMP: w_readMux = TIMESTAMP;
      ADDR_UPTIME_LO: w_readMux = r_counter[31:0];
      ADDR_UPTIME_HI: w_readMux = r_hiShadow;
      ADDR_SCRATCH:   w_readMux = r_scratch;
      ADDR_CAPS:      w_readMux = CAPS_WORD;
      default: begin
        for (int k = 0; k < NUM_USER; k++) begin
          if (bus.address == ADDR_W'(6 + k)) begin
            w_readMux = USER_WORDS[k*32 +: 32];
          end
        end
      end
    endcase
  end

  // Byte-lane merge for scratch writes.
  always_comb begin
    w_scratchNext = r_scratch;
    for (int b = 0; b < 4; b++) begin
      if (bus.byteenable[b]) begin
        w_scratchNext[8*b +: 8] = bus.writedata[8*b +: 8];
      end
    end
  end

  // Prescaler and 64-bit uptime counter; a clear write beats a tick.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_counter <= '0;
      r_preCnt  <= '0;
    end else if (w_clear) begin
      r_counter <= '0;
      r_preCnt  <= '0;
    end else if (w_tick) begin
      r_counter <= r_counter + 64'd1;
      r_preCnt  <= '0;
    end else begin
      r_preCnt  <= r_preCnt + 16'd1;
    end
  end

  // Registered read path; only a LO read refreshes the high-word shadow.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_readdata      <= '0;
      r_readdatavalid <= 1'b0;
      r_hiShadow      <= '0;
    end else begin
      r_readdatavalid <= bus.read;
      if (bus.read) begin
        r_readdata <= w_readMux;
        if (bus.address == ADDR_UPTIME_LO) begin
          r_hiShadow <= r_counter[63:32];
        end
      end
    end
  end

  // Scratch register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_scratch <= '0;
    end else if (w_wrEn && (bus.address == ADDR_SCRATCH)) begin
      r_scratch <= w_scratchNext;
    end
  end

endmodule

// File: tb/tb_sysid_info_regs.sv
// ---------------------------------------------------------------------------
// tb_sysid_info_regs
// Directed plus randomized bench for sysid_info_regs, checked against a
// transaction-level model of the register map and uptime counter.
// ---------------------------------------------------------------------------
module tb_sysid_info_regs;

  localparam int PRESCALE = 4;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;

  sysid_info_regs_if #(.ADDR_W(4)) bus ();

  sysid_info_regs #(
    .SYSTEM_ID  (32'h511E_D0FA),
    .TIMESTAMP  (32'd0),
    .VERSION    (8'd2),
    .ADDR_W     (4),
    .NUM_USER   (2),
    .USER_WORDS ({32'h0000_BEEF, 32'h0000_CAFE}),
    .PRESCALE   (PRESCALE)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // 100 MHz-style free-running clock.
  always #5 clock = ~clock;

  int testsRun    = 0;
  int testsFailed = 0;

  // Reference model state: whole-counter arithmetic, no prescaler encoding.
  logic [63:0] mCounter;
  int          mPre;
  logic [31:0] mShadow;
  logic [31:0] mScratch;
  logic [31:0] mRdata;
  logic        mRdv;
  logic [31:0] userWords [2] = '{32'h0000_CAFE, 32'h0000_BEEF};

  function automatic void modelReset();
    mCounter = '0;
    mPre     = 0;
    mShadow  = '0;
    mScratch = '0;
    mRdata   = '0;
    mRdv     = 1'b0;
  endfunction

  function automatic logic [31:0] modelRead(input int addr);
    case (addr)
      0:       return 32'h511E_D0FA;
      1:       return 32'd0;
      2:       return mCounter[31:0];
      3:       return mShadow;
      4:       return mScratch;
      5:       return 32'h0002_0402;
      6, 7:    return userWords[addr-6];
      default: return 32'd0;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // One bus cycle: drive, clock, advance the model, compare both outputs.
  task automatic applyStimulus(input logic rd, input logic wr, input int addr,
                               input logic [31:0] wdata, input logic [3:0] be);
    logic clr;
    bus.read       = rd;
    bus.write      = wr;
    bus.address    = 4'(addr);
    bus.writedata  = wdata;
    bus.byteenable = be;
    @(posedge clock);
    #1;
    clr = 1'b0;
    if (rd) begin
      mRdata = modelRead(addr);
      mRdv   = 1'b1;
      if (addr == 2) mShadow = mCounter[63:32];
    end else begin
      mRdv = 1'b0;
    end
    if (wr && !rd) begin
      if (addr == 2) clr = 1'b1;
      if (addr == 4) begin
        for (int b = 0; b < 4; b++)
          if (be[b]) mScratch[8*b +: 8] = wdata[8*b +: 8];
      end
    end
    if (clr) begin
      mCounter = '0;
      mPre     = 0;
    end else begin
      mPre = mPre + 1;
      if (mPre == PRESCALE) begin
        mPre     = 0;
        mCounter = mCounter + 64'd1;
      end
    end
    checkOutput($sformatf("rdv a%0d", addr), 32'(bus.readdatavalid), 32'(mRdv));
    checkOutput($sformatf("rdata a%0d", addr), bus.readdata, mRdata);
    bus.read  = 1'b0;
    bus.write = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 0, 32'd0, 4'd0);
  endtask

  task automatic forceCounter(input logic [63:0] value);
    force dut.r_counter = value;
    #1;
    release dut.r_counter;
    mCounter = value;
  endtask

  initial begin
    bus.address    = '0;
    bus.read       = 1'b0;
    bus.write      = 1'b0;
    bus.writedata  = '0;
    bus.byteenable = '0;
    modelReset();

    // Reset values.
    repeat (3) @(posedge clock);
    #1;
    checkOutput("reset rdata", bus.readdata, 32'd0);
    checkOutput("reset rdv", 32'(bus.readdatavalid), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;

    // Identity words with idle gaps to prove single-cycle valid pulses.
    applyStimulus(1'b1, 1'b0, 0, 32'd0, 4'd0);
    checkOutput("sysid", bus.readdata, 32'h511E_D0FA);
    idle(1);
    applyStimulus(1'b1, 1'b0, 1, 32'd0, 4'd0);
    checkOutput("timestamp", bus.readdata, 32'd0);
    idle(1);
    applyStimulus(1'b1, 1'b0, 5, 32'd0, 4'd0);
    checkOutput("caps", bus.readdata, 32'h0002_0402);
    idle(2);

    // Back-to-back user words and an unmapped address.
    applyStimulus(1'b1, 1'b0, 6, 32'd0, 4'd0);
    checkOutput("user0", bus.readdata, 32'h0000_CAFE);
    applyStimulus(1'b1, 1'b0, 7, 32'd0, 4'd0);
    checkOutput("user1", bus.readdata, 32'h0000_BEEF);
    applyStimulus(1'b1, 1'b0, 15, 32'd0, 4'd0);
    checkOutput("unmapped", bus.readdata, 32'd0);
    checkOutput("b2b rdv", 32'(bus.readdatavalid), 32'd1);

    // Scratch byte enables, then read-and-write collision.
    applyStimulus(1'b0, 1'b1, 4, 32'hFFFF_FFFF, 4'hF);
    applyStimulus(1'b0, 1'b1, 4, 32'h1234_5678, 4'b0101);
    applyStimulus(1'b1, 1'b0, 4, 32'd0, 4'd0);
    checkOutput("scratch merge", bus.readdata, 32'hFF34_FF78);
    applyStimulus(1'b1, 1'b1, 4, 32'h0000_0000, 4'hF);
    checkOutput("rw collide", bus.readdata, 32'hFF34_FF78);
    applyStimulus(1'b1, 1'b0, 4, 32'd0, 4'd0);
    checkOutput("scratch kept", bus.readdata, 32'hFF34_FF78);
    applyStimulus(1'b0, 1'b1, 0, 32'hDEAD_BEEF, 4'hF);
    applyStimulus(1'b1, 1'b0, 0, 32'd0, 4'd0);
    checkOutput("ro write", bus.readdata, 32'h511E_D0FA);

    // Prescaled uptime: 40 idle cycles at PRESCALE=4 give 10 ticks.
    applyStimulus(1'b0, 1'b1, 2, 32'd0, 4'd0);
    idle(40);
    applyStimulus(1'b1, 1'b0, 2, 32'd0, 4'd0);
    checkOutput("uptime 10", bus.readdata, 32'd10);

    // 32-bit carry into the high word.
    forceCounter(64'h0000_0000_FFFF_FFFF);
    idle(4);
    applyStimulus(1'b1, 1'b0, 2, 32'd0, 4'd0);
    checkOutput("carry lo", bus.readdata, 32'd0);
    applyStimulus(1'b1, 1'b0, 3, 32'd0, 4'd0);
    checkOutput("carry hi", bus.readdata, 32'd1);

    // Shadow coherence: HI comes from the LO read, not the live counter.
    applyStimulus(1'b0, 1'b1, 2, 32'd0, 4'd0);
    forceCounter(64'h0000_0000_FFFF_FFFF);
    applyStimulus(1'b1, 1'b0, 2, 32'd0, 4'd0);
    checkOutput("shadow lo", bus.readdata, 32'hFFFF_FFFF);
    idle(4);
    applyStimulus(1'b1, 1'b0, 3, 32'd0, 4'd0);
    checkOutput("shadow hi", bus.readdata, 32'd0);

    // 64-bit wrap to zero.
    forceCounter(64'hFFFF_FFFF_FFFF_FFFF);
    idle(4);
    applyStimulus(1'b1, 1'b0, 2, 32'd0, 4'd0);
    applyStimulus(1'b1, 1'b0, 3, 32'd0, 4'd0);
    checkOutput("wrap hi", bus.readdata, 32'd0);

    // Reset asserted right after a read with another read pending.
    applyStimulus(1'b1, 1'b0, 4, 32'd0, 4'd0);
    bus.read    = 1'b1;
    bus.address = 4'd0;
    reset_n     = 1'b0;
    #1;
    checkOutput("rst async rdv", 32'(bus.readdatavalid), 32'd0);
    checkOutput("rst async rdata", bus.readdata, 32'd0);
    @(posedge clock);
    #1;
    checkOutput("rst held rdv", 32'(bus.readdatavalid), 32'd0);
    bus.read = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    modelReset();
    idle(1);
    applyStimulus(1'b1, 1'b0, 4, 32'd0, 4'd0);
    checkOutput("scratch reset", bus.readdata, 32'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 300; i++) begin
      applyStimulus($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
                    int'($urandom_range(0, 15)), $urandom, 4'($urandom_range(0, 15)));
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
